imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

  localparam int INSTR_W = 18;
  localparam int HDR_LEN = 2;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    B0,
    B1,
    B2,
`ifdef IMEM_LOADER_CKSUM_EN
    CKSUM,
`endif
    DONE,
    ERR
  } state_e;

  // State entered once the word stream (possibly empty) has been consumed.
`ifdef IMEM_LOADER_CKSUM_EN
  localparam state_e AFTER_WORDS = CKSUM;
`else
  localparam state_e AFTER_WORDS = DONE;
`endif

endpackage

// File: rtl/imem_loader.sv
// Byte-serial program loader: header (word count), 3 bytes per 18-bit word,
// optional XOR checksum when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  state_e               state_q, state_d;
  logic [7:0]           n_lo_q, n_lo_d;
  logic [15:0]          rem_q, rem_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [15:0]          word_q, word_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]           xor_q, xor_d;
`endif

  logic        accept;
  logic        can_start;
  logic [15:0] hdr_n;

  assign accept    = rx_valid & rx_ready;
  assign can_start = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign hdr_n     = {rx_data, n_lo_q};

  // NOTE: every variable gets its hold/default value before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    n_lo_d  = n_lo_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CKSUM_EN
    xor_d   = xor_q;
`endif

    if (load_req && can_start) begin
      state_d = HDR0;
      idx_d   = '0;
`ifdef IMEM_LOADER_CKSUM_EN
      xor_d   = '0;
`endif
    end else if (accept) begin
`ifdef IMEM_LOADER_CKSUM_EN
      if (state_q != CKSUM) xor_d = xor_q ^ rx_data;
`endif
      unique case (state_q)
        HDR0: begin
          n_lo_d  = rx_data;
          state_d = HDR1;
        end
        HDR1: begin
          rem_d = hdr_n;
          if (int'(hdr_n) > DEPTH) state_d = ERR;
          else if (hdr_n == 16'd0) state_d = AFTER_WORDS;
          else                     state_d = B0;
        end
        B0: begin
          word_d[7:0] = rx_data;
          state_d     = B1;
        end
        B1: begin
          word_d[15:8] = rx_data;
          state_d      = B2;
        end
        B2: begin
          // Only the two low bits of the third byte belong to the word.
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = {rx_data[1:0], word_q};
          idx_d   = idx_q + ADDR_W'(1);
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? AFTER_WORDS : B0;
        end
`ifdef IMEM_LOADER_CKSUM_EN
        CKSUM: state_d = (rx_data == xor_q) ? DONE : ERR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the block holds no memory array, so each
  // register can be cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_lo_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_lo_q  <= n_lo_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  assign rx_ready = state_q inside {HDR0, HDR1, B0, B1, B2, CKSUM};
`else
  assign rx_ready = state_q inside {HDR0, HDR1, B0, B1, B2};
`endif
  assign cpu_hold   = !(state_q inside {IDLE, DONE});
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule
